// File: rtl/vdpu_pkg.sv
// vdpu_pkg: shared constants, types and helpers for the vdpu group stages
// (group reduction and its inverse, group broadcast).
//   LANES     - elements per dense beat, and max scalars per packed beat
//   WIDTH     - signed element width
//   MAX_IN    - max elements one packed beat may expand into
//   BUF_DEPTH - broadcast staging buffer entries (>= LANES-1+MAX_IN)
package vdpu_pkg;

  localparam int LANES     = 8;
  localparam int WIDTH     = 32;
  localparam int MAX_IN    = 12;
  localparam int BUF_DEPTH = 20;

  typedef logic signed [WIDTH-1:0] elem_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } bcast_state_e;

  // Group sizes both stages support; anything else falls back to 1.
  function automatic logic is_legal_group(input logic [3:0] size);
    case (size)
      4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/group_expand_unit.sv
// group_expand_unit: combinational replication of packed group scalars.
// Scalar lane k is copied into element slots k*g .. k*g+g-1 of a
// MAX_IN-entry vector, lane 0's group first.
//   in_data  - packed group scalars, lane 0 first
//   in_count - number of valid scalars
//   cfg_g    - group size in effect (already sanitised to a legal value)
//   elems    - expanded element vector; slots past the groups are don't-care
//   elem_cnt - in_count*cfg_g, full width so oversize beats can be detected
module group_expand_unit
  import vdpu_pkg::*;
#(
  parameter int LANES  = vdpu_pkg::LANES,
  parameter int WIDTH  = vdpu_pkg::WIDTH,
  parameter int MAX_IN = vdpu_pkg::MAX_IN
) (
  input  logic signed [WIDTH-1:0] in_data [LANES],
  input  logic        [3:0]       in_count,
  input  logic        [3:0]       cfg_g,
  output logic signed [WIDTH-1:0] elems   [MAX_IN],
  output logic        [7:0]       elem_cnt
);

  assign elem_cnt = {4'd0, in_count} * {4'd0, cfg_g};

  // Every slot checks which lane's group window it falls into, so all array
  // indices are elaboration-time constants and only the compare is dynamic.
  always_comb begin
    // NOTE: each slot gets a default before the conditional writes so no
    // latch is inferred for slots no group covers.
    for (int e = 0; e < MAX_IN; e++) begin
      elems[e] = '0;
      for (int k = 0; k < LANES; k++) begin
        if (e >= k * int'(cfg_g) && e < (k + 1) * int'(cfg_g)) begin
          elems[e] = in_data[k];
        end
      end
    end
  end

endmodule

// File: rtl/group_broadcast.sv
// group_broadcast: expands packed per-group scalars back across the
// element positions of each group and emits dense LANES-wide beats.
//   clk, nrst                  - clock, asynchronous active-low reset
//   group_size                 - elements per group, latched at vector start
//   in_valid/in_ready          - packed input beat handshake
//   in_data/in_count/in_last   - packed scalars, valid count, end of vector
//   out_valid/out_ready        - dense output beat handshake
//   out_data/out_last          - buffer head, final beat of the vector
//   cfg_err                    - sticky illegal-config / oversize-beat flag
module group_broadcast
  import vdpu_pkg::*;
#(
  parameter int LANES     = vdpu_pkg::LANES,
  parameter int WIDTH     = vdpu_pkg::WIDTH,
  parameter int MAX_IN    = vdpu_pkg::MAX_IN,
  parameter int BUF_DEPTH = vdpu_pkg::BUF_DEPTH
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic        [3:0]       group_size,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data  [LANES],
  input  logic        [3:0]       in_count,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data [LANES],
  output logic                    out_last,
  output logic                    cfg_err
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LANES_C  = cnt_t'(LANES);
  // Highest fill at which a worst-case beat still fits in the buffer.
  localparam cnt_t READY_TH = cnt_t'(BUF_DEPTH - MAX_IN);

  bcast_state_e            state;
  logic        [3:0]       cfg_g;
  cnt_t                    fill_cnt;
  logic signed [WIDTH-1:0] buffer   [BUF_DEPTH];
  logic signed [WIDTH-1:0] buf_next [BUF_DEPTH];

  logic signed [WIDTH-1:0] exp_elems [MAX_IN];
  logic        [7:0]       exp_cnt;
  logic        [3:0]       g_sel;
  logic        [3:0]       g_use;
  logic                    accept;
  logic                    pop;
  logic                    drop;
  cnt_t                    app_cnt;
  cnt_t                    pop_cnt;
  cnt_t                    remain;
  cnt_t                    fill_next;

  // Handshake outputs derive only from registers, never from out_ready.
  assign in_ready  = (state != FLUSH) && (fill_cnt <= READY_TH);
  assign out_valid = (fill_cnt >= LANES_C) || (state == FLUSH);
  assign out_last  = (state == FLUSH) && (fill_cnt <= LANES_C);

  // Entries at or past fill_cnt are kept zero, so the head is already the
  // zero-padded partial beat during a flush.
  always_comb begin
    for (int i = 0; i < LANES; i++) out_data[i] = buffer[i];
  end

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  // The beat that opens a vector expands with the size it is about to latch.
  assign g_sel = is_legal_group(group_size) ? group_size : 4'd1;
  assign g_use = (state == IDLE) ? g_sel : cfg_g;

  group_expand_unit #(
    .LANES  (LANES),
    .WIDTH  (WIDTH),
    .MAX_IN (MAX_IN)
  ) u_expand (
    .in_data  (in_data),
    .in_count (in_count),
    .cfg_g    (g_use),
    .elems    (exp_elems),
    .elem_cnt (exp_cnt)
  );

  assign drop    = (in_count > 4'(LANES)) || (exp_cnt > 8'(MAX_IN));
  assign app_cnt = (accept && !drop) ? cnt_t'(exp_cnt) : '0;
  // Outside FLUSH a pop only happens with a full beat buffered.
  assign pop_cnt = !pop ? '0 : (fill_cnt >= LANES_C) ? LANES_C : fill_cnt;
  assign remain    = fill_cnt - pop_cnt;
  assign fill_next = remain + app_cnt;

  // Surviving entries shift down by pop_cnt; new elements go right behind
  // them. Shift amounts are enumerated so indices stay constant.
  always_comb begin
    for (int i = 0; i < BUF_DEPTH; i++) begin
      buf_next[i] = '0;
      if (i < int'(remain)) begin
        for (int s = 0; s <= LANES; s++) begin
          if (int'(pop_cnt) == s) buf_next[i] = buffer[(i + s) % BUF_DEPTH];
        end
      end else if (i < int'(remain) + int'(app_cnt)) begin
        for (int e = 0; e < MAX_IN; e++) begin
          if (int'(remain) + e == i) buf_next[i] = exp_elems[e];
        end
      end
    end
  end

  // NOTE: the staging buffer is reset along with the control state because
  // its head drives out_data directly and must read zero out of reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      cfg_g    <= 4'd1;
      fill_cnt <= '0;
      cfg_err  <= 1'b0;
      for (int i = 0; i < BUF_DEPTH; i++) buffer[i] <= '0;
    end else begin
      // NOTE: all state here updates with non-blocking assignments so every
      // register sees pre-edge values of the others.
      fill_cnt <= fill_next;
      for (int i = 0; i < BUF_DEPTH; i++) buffer[i] <= buf_next[i];

      if (accept && (drop || (state == IDLE && !is_legal_group(group_size)))) begin
        cfg_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            cfg_g <= g_sel;
            state <= in_last ? FLUSH : RUN;
          end
        end
        RUN: begin
          if (accept && in_last) state <= FLUSH;
        end
        FLUSH: begin
          if (pop && out_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_group_broadcast.sv
// tb_group_broadcast: self-checking bench for group_broadcast. A queue-based
// reference model tracks the expected element stream and vector status;
// directed vectors are followed by randomized ones.
module tb_group_broadcast;
  import vdpu_pkg::*;

  logic        clk = 1'b0;
  logic        nrst;
  logic [3:0]  group_size;
  logic        in_valid;
  logic        in_ready;
  elem_t       in_data [LANES];
  logic [3:0]  in_count;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  elem_t       out_data [LANES];
  logic        out_last;
  logic        cfg_err;

  always #5 clk = ~clk;

  group_broadcast dut (
    .clk        (clk),
    .nrst       (nrst),
    .group_size (group_size),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_count   (in_count),
    .in_last    (in_last),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .cfg_err    (cfg_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  elem_t q[$];
  bit    m_open, m_flush, m_err;
  int    m_g;
  bit    rand_ready;
  elem_t got[$];
  bit    got_last[$];

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic bit legal(input int g);
    return g inside {1, 2, 3, 4, 6, 8};
  endfunction

  task automatic model_clear();
    q.delete();
    m_open = 0; m_flush = 0; m_err = 0; m_g = 1;
  endtask

  task automatic model_accept();
    int cnt, g;
    if (!m_open && !m_flush) begin
      g = int'(group_size);
      if (!legal(g)) begin g = 1; m_err = 1; end
      m_g = g;
    end
    cnt = int'(in_count);
    if (cnt > LANES || cnt * m_g > MAX_IN) m_err = 1;
    else
      for (int k = 0; k < cnt; k++) repeat (m_g) q.push_back(in_data[k]);
    if (in_last) m_flush = 1; else m_open = 1;
  endtask

  // One clock: check outputs before the edge, then advance the model.
  task automatic cycle(output bit acc);
    bit e_ready, e_valid, e_last, pp;
    int n;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    @(negedge clk);
    e_ready = !m_flush && (q.size() <= BUF_DEPTH - MAX_IN);
    e_valid = (q.size() >= LANES) || m_flush;
    e_last  = m_flush && (q.size() <= LANES);
    check("in_ready", in_ready, e_ready);
    check("out_valid", out_valid, e_valid);
    check("out_last", out_last, e_last);
    check("cfg_err", cfg_err, m_err);
    if (e_valid)
      for (int i = 0; i < LANES; i++)
        check($sformatf("out_data[%0d]", i), out_data[i],
              (i < q.size()) ? q[i] : elem_t'(0));
    acc = in_valid && e_ready;
    pp  = e_valid && out_ready;
    @(posedge clk);
    #1;
    if (pp) begin
      for (int i = 0; i < LANES; i++) got.push_back((i < q.size()) ? q[i] : elem_t'(0));
      got_last.push_back(e_last);
      n = (q.size() < LANES) ? q.size() : LANES;
      repeat (n) void'(q.pop_front());
      if (e_last) begin m_flush = 0; m_open = 0; end
    end
    if (acc) model_accept();
  endtask

  task automatic send_beat(input int gs, input int cnt, input elem_t v [LANES],
                           input bit last);
    bit acc;
    int t = 0;
    in_valid = 1; group_size = 4'(gs); in_count = 4'(cnt); in_data = v; in_last = last;
    do begin cycle(acc); t++; end while (!acc && t < 200);
    check("accept_timeout", {31'd0, acc}, 1);
    in_valid = 0; in_last = 0;
  endtask

  task automatic drain();
    bit acc;
    int t = 0;
    while ((m_open || m_flush || q.size() != 0) && t < 300) begin cycle(acc); t++; end
    check("drain_timeout", (t < 300) ? 1 : 0, 1);
  endtask

  task automatic check_got(input string tag, input int ev[$], input bit lv[$]);
    check({tag, "_elems"}, got.size(), ev.size());
    for (int i = 0; i < ev.size() && i < got.size(); i++)
      check($sformatf("%s_e%0d", tag, i), got[i], ev[i]);
    check({tag, "_beats"}, got_last.size(), lv.size());
    for (int i = 0; i < lv.size() && i < got_last.size(); i++)
      check($sformatf("%s_last%0d", tag, i), got_last[i], lv[i]);
    got.delete(); got_last.delete();
  endtask

  initial begin
    elem_t v [LANES];
    int    ev[$];
    bit    lv[$];
    bit    acc;
    int    nb, gs, g, cnt, cmax;

    nrst = 0; group_size = 0; in_valid = 0; in_count = 0; in_last = 0;
    out_ready = 1; rand_ready = 0;
    for (int i = 0; i < LANES; i++) in_data[i] = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_last", out_last, 0);
    check("rst_cfg_err", cfg_err, 0);
    for (int i = 0; i < LANES; i++) check($sformatf("rst_out_data[%0d]", i), out_data[i], 0);
    @(negedge clk); nrst = 1;
    @(posedge clk); #1;

    // G=3: groups straddle beat boundaries.
    v = '{10, 20, 0, 0, 0, 0, 0, 0};  send_beat(3, 2, v, 0);
    v = '{30, 40, 50, 0, 0, 0, 0, 0}; send_beat(3, 3, v, 0);
    v = '{60, 70, 80, 0, 0, 0, 0, 0}; send_beat(3, 3, v, 1);
    drain();
    ev = '{10,10,10,20,20,20,30,30, 30,40,40,40,50,50,50,60, 60,60,70,70,70,80,80,80};
    lv = '{0, 0, 1};
    check_got("g3", ev, lv);

    // G=6.
    v = '{1, 0, 0, 0, 0, 0, 0, 0}; send_beat(6, 1, v, 0);
    v = '{2, 0, 0, 0, 0, 0, 0, 0}; send_beat(6, 1, v, 0);
    v = '{3, 4, 0, 0, 0, 0, 0, 0}; send_beat(6, 2, v, 1);
    drain();
    ev = '{1,1,1,1,1,1,2,2, 2,2,2,2,3,3,3,3, 3,3,4,4,4,4,4,4};
    lv = '{0, 0, 1};
    check_got("g6", ev, lv);

    // G=2 single short beat, zero padded.
    v = '{-5, 7, 9, 0, 0, 0, 0, 0}; send_beat(2, 3, v, 1);
    drain();
    ev = '{-5,-5,7,7,9,9,0,0};
    lv = '{1};
    check_got("g2", ev, lv);

    // Backpressure with G=1 full beats.
    out_ready = 0;
    v = '{1, 2, 3, 4, 5, 6, 7, 8};         send_beat(1, 8, v, 0);
    v = '{9, 10, 11, 12, 13, 14, 15, 16};  send_beat(1, 8, v, 0);
    in_valid = 1; in_data = '{17, 18, 19, 20, 21, 22, 23, 24}; in_count = 8; in_last = 1;
    repeat (5) begin
      cycle(acc);
      check("bp_stalled", {31'd0, acc}, 0);
    end
    out_ready = 1;
    nb = 0;
    do begin cycle(acc); nb++; end while (!acc && nb < 50);
    check("bp_accept", {31'd0, acc}, 1);
    in_valid = 0; in_last = 0;
    drain();
    ev.delete();
    for (int i = 1; i <= 24; i++) ev.push_back(i);
    lv = '{0, 0, 1};
    check_got("bp", ev, lv);

    // Illegal group size: replicated x1, error flagged.
    v = '{7, 8, 0, 0, 0, 0, 0, 0}; send_beat(5, 2, v, 1);
    drain();
    check("g5_cfg_err", cfg_err, 1);
    ev = '{7,8,0,0,0,0,0,0};
    lv = '{1};
    check_got("g5", ev, lv);

    // Oversize beat dropped; flush of an empty buffer gives one zero beat.
    v = '{1, 2, 3, 0, 0, 0, 0, 0}; send_beat(8, 3, v, 1);
    drain();
    check("drop_cfg_err", cfg_err, 1);
    ev = '{0,0,0,0,0,0,0,0};
    lv = '{1};
    check_got("drop", ev, lv);

    // Reset mid-vector with 5 elements buffered.
    v = '{1, 2, 3, 4, 5, 0, 0, 0}; send_beat(1, 5, v, 0);
    cycle(acc);
    check("pre_rst_fill", q.size(), 5);
    @(negedge clk); nrst = 0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_cfg_err", cfg_err, 0);
    check("mid_rst_out_last", out_last, 0);
    @(posedge clk);
    @(negedge clk); nrst = 1;
    model_clear(); got.delete(); got_last.delete();
    @(posedge clk); #1;

    // Fresh G=4 vector after reset.
    v = '{11, -12, 0, 0, 0, 0, 0, 0}; send_beat(4, 2, v, 0);
    v = '{13, 14, 15, 0, 0, 0, 0, 0}; send_beat(4, 3, v, 1);
    drain();
    ev.delete();
    foreach (v[k]) ;
    for (int s = 0; s < 5; s++) repeat (4) ev.push_back((s == 0) ? 11 : (s == 1) ? -12 : 11 + s);
    repeat (4) ev.push_back(0);
    lv = '{0, 0, 1};
    check_got("g4", ev, lv);

    // Randomized vectors with random output stalls and idle gaps.
    rand_ready = 1;
    for (int n = 0; n < 25; n++) begin
      nb = $urandom_range(1, 4);
      gs = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                       : int'($urandom_range(1, 8));
      g  = legal(gs) ? gs : 1;
      for (int b = 0; b < nb; b++) begin
        cmax = (MAX_IN / g < LANES) ? MAX_IN / g : LANES;
        cnt  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15))
                                           : int'($urandom_range(0, cmax));
        for (int i = 0; i < LANES; i++) v[i] = elem_t'($urandom);
        send_beat((b == 0) ? gs : int'($urandom_range(0, 15)), cnt, v, b == nb - 1);
        repeat ($urandom_range(0, 2)) cycle(acc);
      end
      drain();
      got.delete(); got_last.delete();
    end
    rand_ready = 0; out_ready = 1;
    repeat (2) cycle(acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/group_broadcast.md
Name: group_broadcast

Overview:
Inverse of the vdpu group reduction stage. It takes packed per-group scalars (lanes 0..in_count-1, one scalar per group of group_size elements) and expands each scalar back across the element positions of its group. It emits dense LANES-wide element beats. Typical uses are broadcasting a group sum or scale back onto the data lanes for normalisation; group sizes 3 and 6 straddle beat boundaries and need a residual buffer.

Parameters:
LANES, 8, elements per output beat and max scalars per input beat
WIDTH, 32, signed element width
MAX_IN, 12, max elements produced by one input beat (in_count*group_size)
BUF_DEPTH, 20, element staging buffer entries (must be >= LANES-1+MAX_IN)

Ports:
clk  in  1  clock
nrst  in  1  reset, asynchronous, active-low
group_size  in  4  elements per group; legal 1,2,3,4,6,8
in_valid  in  1  input beat valid
in_ready  out  1  input beat accepted when in_valid&&in_ready
in_data  in  LANES x WIDTH signed  packed group scalars, lane 0 first
in_count  in  4  number of valid scalars in in_data (0..LANES)
in_last  in  1  final input beat of a vector; triggers flush
out_valid  out  1  output beat valid
out_ready  in  1  output beat consumed when out_valid&&out_ready
out_data  out  LANES x WIDTH signed  expanded elements
out_last  out  1  final output beat of the vector
cfg_err  out  1  sticky illegal-config/overflow flag

Behaviour:
- Reset: buffer empty, fill_cnt=0, state IDLE, cfg_g=1, in_ready=1, out_valid=0, out_last=0, out_data=0, cfg_err=0. Reset mid-vector discards all buffered elements.
- States: IDLE (fill 0, no vector open), RUN, FLUSH.
- IDLE->RUN on the first accepted beat with in_last=0. IDLE->FLUSH on an accepted beat with in_last=1. RUN->FLUSH when in_last is accepted. FLUSH->IDLE when the out_last beat is consumed.
- group_size is latched into cfg_g only on a beat accepted in IDLE and held for the whole vector.
- Illegal group_size (0,5,7,>8): cfg_g=1, cfg_err set.
- Expansion: scalar in_data[k] becomes cfg_g consecutive elements. Element order is lane 0's group first. The beat appends in_count*cfg_g elements at the buffer tail.
- in_count>LANES or in_count*cfg_g>MAX_IN: beat is accepted and dropped, cfg_err set. in_last is still honoured.
- in_ready = (state!=FLUSH) && (fill_cnt <= BUF_DEPTH-MAX_IN). It depends only on registered state, with no combinational path from out_ready.
- out_valid = fill_cnt>=LANES, or (state==FLUSH).
- out_data is the buffer head, registered storage. In FLUSH with fill_cnt<LANES, lanes >= fill_cnt are zero.
- out_last=1 on the beat that leaves the buffer empty while in FLUSH. If a flush starts with fill_cnt=0, the block emits one all-zero beat with out_last=1.
- Pop removes LANES elements, or all remaining in FLUSH, and shifts the remainder to the head.
- Simultaneous accept and pop in one cycle: fill_next = fill - popped + appended. Appended elements land after the remaining ones.
- Latency: elements accepted at edge t are visible on out_data at t+1 at the earliest.
- Backpressure: out_data and out_last hold stable while out_valid&&!out_ready.
- Arithmetic: pure replication, no width change, signedness preserved. fill_cnt is 5 bits and saturation is impossible by the in_ready rule.
- cfg_err clears only on reset.

Decomposition:
- Package vdpu_pkg: LANES, WIDTH, MAX_IN constants; elem_t (signed WIDTH) typedef; bcast_state_e enum {IDLE,RUN,FLUSH}; function is_legal_group(size) shared with the reduction stage.
- Sub-module group_expand_unit: combinational. Maps in_data, in_count and cfg_g to a MAX_IN-entry element vector plus an element count.
- The top module holds the FSM, the staging buffer and the handshakes.

Test Plan:
- G=3, beats counts 2,3,3 with {10,20},{30,40,50},{60,70,80}, last on the third beat, out_ready=1 -> three beats:
  - {10,10,10,20,20,20,30,30}
  - {30,40,40,40,50,50,50,60}
  - {60,60,70,70,70,80,80,80}, out_last on the third only.
- G=6, counts 1,1,2 with {1},{2},{3,4}, last -> beats {1,1,1,1,1,1,2,2}, {2,2,2,2,3,3,3,3}, {3,3,4,4,4,4,4,4}+last.
- G=2, one beat count 3 {-5,7,9} with in_last -> single beat {-5,-5,7,7,9,9,0,0}, out_last=1.
- Backpressure: G=1, count 8 beats, out_ready=0 for 5 cycles -> in_ready drops once fill>8, no beat lost, out_data stable while stalled, order preserved on release.
- group_size=5 -> cfg_err=1, elements replicated x1. in_count=3 with G=8 -> beat dropped, cfg_err=1.
- Assert nrst mid-vector with fill=5 -> out_valid=0, in_ready=1 next cycle; a new G=4 vector expands correctly.
